regfile_write_arbiter: RTL and testbench

Owns the single write port of the 32x32 register file and shares it between two writeback requesters: ALU result and memory load.
- Arbitration is round-robin with valid/ready handshakes.
- One registered write is issued per cycle.
- After reset, it first sequences a clear of every register to zero.
- Sits between the execute/memory writeback stages and the register file's write_enable/write_address/data_in inputs.

---
 rtl/regfile_write_arbiter_pkg.sv | 11 +
 rtl/rr_arbiter2.sv | 44 ++++
 rtl/regfile_write_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter and its round-robin core.
package regfile_write_arbiter_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic {GRANT_ALU, GRANT_MEM} grant_t;

    localparam int          ZERO_REG       = 0;
    localparam int          CONFLICT_WIDTH = 16;
    localparam logic [15:0] CONFLICT_MAX   = 16'hFFFF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grants, registered last-winner.
// Requester A maps to GRANT_ALU and requester B to GRANT_MEM in the last-winner encoding.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b
);

    grant_t last_grant;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (enable) begin
            if (req_a && req_b) begin
                grant_a = (last_grant == GRANT_MEM);
                grant_b = (last_grant == GRANT_ALU);
            end else begin
                grant_a = req_a;
                grant_b = req_b;
            end
        end
    end

    // A grant is only ever given to a requesting input, so a grant is the handshake.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= GRANT_MEM;
        end else if (grant_a) begin
            last_grant <= GRANT_ALU;
        end else if (grant_b) begin
            last_grant <= GRANT_MEM;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU and load writeback, one registered write per cycle.
// Define REGFILE_INIT_EN to clear every register after reset before accepting requests.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ADDR_WIDTH-1:0]     alu_address,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [ADDR_WIDTH-1:0]     mem_address,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      write_enable,
    output logic [ADDR_WIDTH-1:0]     write_address,
    output logic [DATA_WIDTH-1:0]     data_in,
    output logic                      init_busy,
    output logic [CONFLICT_WIDTH-1:0] conflict_count
);

    logic                  in_run;
    logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef REGFILE_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_INIT;
            sweep_count <= '0;
        end else if (state == ST_INIT) begin
            sweep_count <= sweep_count + 1'b1;
            if (sweep_count == LAST_REG) begin
                state <= ST_RUN;
            end
        end
    end

    assign in_run     = (state == ST_RUN);
    assign sweep_addr = sweep_count;
    assign init_busy  = (state == ST_INIT);
`else
    assign in_run     = 1'b1;
    assign sweep_addr = '0;
    assign init_busy  = 1'b0;
`endif

    logic alu_grant;
    logic mem_grant;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (in_run),
        .req_a   (alu_valid),
        .req_b   (mem_valid),
        .grant_a (alu_grant),
        .grant_b (mem_grant)
    );

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    // Register 0 is hardwired zero: its handshakes complete but never strobe the file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            data_in       <= '0;
        end else if (!in_run) begin
            write_enable  <= 1'b1;
            write_address <= sweep_addr;
            data_in       <= '0;
        end else if (alu_grant && alu_address != ADDR_WIDTH'(ZERO_REG)) begin
            write_enable  <= 1'b1;
            write_address <= alu_address;
            data_in       <= alu_data;
        end else if (mem_grant && mem_address != ADDR_WIDTH'(ZERO_REG)) begin
            write_enable  <= 1'b1;
            write_address <= mem_address;
            data_in       <= mem_data;
        end else begin
            write_enable  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_count <= '0;
        end else if (in_run && alu_valid && mem_valid && conflict_count != CONFLICT_MAX) begin
            conflict_count <= conflict_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural arbiter model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_address, mem_address;
    logic [31:0] alu_data, mem_data;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] data_in;
    logic        init_busy;
    logic [15:0] conflict_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model: who won the last tie-relevant grant, and the saturating conflict tally.
    bit mem_won_last;
    int model_conflicts;
    bit a_pend, m_pend;

    regfile_write_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_address    (alu_address),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .data_in        (data_in),
        .init_busy      (init_busy),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Entered just after a rising edge with reset asserted; leaves reset released and the model cleared.
    task automatic do_reset();
        reset_n   = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", write_enable, 0);
        check("rst_addr", write_address, 0);
        check("rst_data", data_in, 0);
        check("rst_conflict", conflict_count, 0);
`ifdef REGFILE_INIT_EN
        check("rst_busy", init_busy, 1);
`else
        check("rst_busy", init_busy, 0);
`endif
        reset_n         = 1'b1;
        mem_won_last    = 1'b1;
        model_conflicts = 0;
    endtask

    // Observe the sweep for n edges; valids are held high to show they are ignored meanwhile.
    task automatic sweep_check(input int n);
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("sweep_alu_ready", alu_ready, 0);
            check("sweep_mem_ready", mem_ready, 0);
            @(posedge clk);
            #1;
            check("sweep_we", write_enable, 1);
            check("sweep_addr", write_address, i);
            check("sweep_data", data_in, 0);
            check("sweep_busy", init_busy, (i < 31) ? 1 : 0);
            if (i == 31) begin
                alu_valid = 1'b0;
                mem_valid = 1'b0;
            end
        end
    endtask

    // One RUN cycle with whatever valids/addresses are currently driven.
    task automatic run_cycle(input bit do_checks);
        bit          exp_a, exp_m;
        logic [4:0]  g_addr;
        logic [31:0] g_data;
        #1;
        exp_a = alu_valid && (!mem_valid || mem_won_last);
        exp_m = mem_valid && !exp_a;
        g_addr = exp_a ? alu_address : mem_address;
        g_data = exp_a ? alu_data : mem_data;
        if (do_checks) begin
            check("alu_ready", alu_ready, exp_a);
            check("mem_ready", mem_ready, exp_m);
        end
        if (alu_valid && mem_valid && model_conflicts < 65535) model_conflicts++;
        if (exp_a) mem_won_last = 1'b0;
        if (exp_m) mem_won_last = 1'b1;
        @(posedge clk);
        #1;
        if (do_checks) begin
            if ((exp_a || exp_m) && g_addr != 0) begin
                check("run_we", write_enable, 1);
                check("run_addr", write_address, g_addr);
                check("run_data", data_in, g_data);
            end else begin
                check("run_we_idle", write_enable, 0);
            end
            check("run_conflict", conflict_count, model_conflicts);
        end
        if (exp_a) a_pend = 1'b0;
        if (exp_m) m_pend = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        alu_address = '0;
        mem_address = '0;
        alu_data    = '0;
        mem_data    = '0;
        a_pend      = 1'b0;
        m_pend      = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Sweep, or (without the sweep) immediate idle RUN.
`ifdef REGFILE_INIT_EN
        alu_address = 5'd7;
        mem_address = 5'd9;
        sweep_check(32);
        check("post_sweep_conflict", conflict_count, 0);
`else
        check("idle_busy", init_busy, 0);
        run_cycle(1);
        run_cycle(1);
`endif

        // Contention: ALU wins the first tie after reset, then strict alternation.
        alu_valid = 1'b1; alu_address = 5'd3; alu_data = 32'd1;
        mem_valid = 1'b1; mem_address = 5'd4; mem_data = 32'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("contend_order", alu_ready, (i % 2 == 0) ? 1 : 0);
            check("contend_not_both", alu_ready && mem_ready, 0);
            @(negedge clk);
            run_cycle(1);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        check("contend_count", conflict_count, 4);

        // Single ALU request.
        alu_valid = 1'b1; alu_address = 5'd5; alu_data = 32'hDEADBEEF;
        run_cycle(1);
        check("single_data", data_in, 32'hDEADBEEF);
        alu_valid = 1'b0;
        run_cycle(1);
        check("hold_addr", write_address, 5);
        check("hold_data", data_in, 32'hDEADBEEF);

        // Register 0: accepted but not written.
        mem_valid = 1'b1; mem_address = 5'd0; mem_data = 32'h12345678;
        #1;
        check("r0_mem_ready", mem_ready, 1);
        @(negedge clk);
        run_cycle(1);
        check("r0_we", write_enable, 0);
        mem_valid = 1'b0;

        // Random traffic: requesters hold until granted.
        for (int c = 0; c < 400; c++) begin
            if (!a_pend && $urandom_range(1, 0) == 1) begin
                a_pend = 1'b1;
                alu_address = 5'($urandom_range(31, 0));
                alu_data = $urandom;
            end
            if (!m_pend && $urandom_range(1, 0) == 1) begin
                m_pend = 1'b1;
                mem_address = 5'($urandom_range(31, 0));
                mem_data = $urandom;
            end
            alu_valid = a_pend;
            mem_valid = m_pend;
            run_cycle(1);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        a_pend = 1'b0;
        m_pend = 1'b0;

        // Saturation of the conflict counter.
        alu_valid = 1'b1; alu_address = 5'd11; alu_data = 32'hA5A5A5A5;
        mem_valid = 1'b1; mem_address = 5'd12; mem_data = 32'h5A5A5A5A;
        for (int c = 0; c < 70000; c++) run_cycle(0);
        check("sat_model", model_conflicts, 65535);
        check("sat_count", conflict_count, 16'hFFFF);
        run_cycle(1);
        check("sat_hold", conflict_count, 16'hFFFF);
        alu_valid = 1'b0;
        mem_valid = 1'b0;

        // Reset mid-operation: outputs clear at once, then the sweep (if any) restarts at 0.
`ifdef REGFILE_INIT_EN
        do_reset();
        sweep_check(11);
        check("mid_addr_before", write_address, 10);
`endif
        reset_n = 1'b0;
        #1;
        check("mid_we", write_enable, 0);
        check("mid_addr", write_address, 0);
        check("mid_data", data_in, 0);
        check("mid_conflict", conflict_count, 0);
        @(posedge clk);
        #1;
        do_reset();
`ifdef REGFILE_INIT_EN
        sweep_check(32);
`else
        alu_valid = 1'b1; alu_address = 5'd20; alu_data = 32'hCAFEF00D;
        run_cycle(1);
        alu_valid = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
